piso_serializer_param: RTL and testbench



---
 rtl/piso_serializer_param.sv | 143 ++++++++++++++
 tb/tb_piso_serializer_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer_param.sv
// piso_serializer_param: MSB-first parallel-to-serial converter on the bit clock clk_8f.
// After reset it sends MIN_IDLE idle symbols to train the link. After that each frame
// carries either data_in or IDLE_SYM.
// Optional build macro SER_PARITY_EN: every frame gets one more bit, an even-parity bit
// (XOR of the loaded word), sent after bit 0.
module piso_serializer_param #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] IDLE_SYM = 8'hBC,
    parameter int                MIN_IDLE = 4
) (
    input  logic              clk_8f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              data_out,
    output logic              ready,
    output logic              word_sync,
    output logic              is_data,
    output logic              link_up
);

`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif

    localparam int CNT_W   = $clog2(DATA_W + 1);
    // Keep train_cnt at least one bit wide so that MIN_IDLE == 0 still builds.
    localparam int TRAIN_W = (MIN_IDLE > 0) ? $clog2(MIN_IDLE + 1) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'((MIN_IDLE > 0) ? MIN_IDLE - 1 : 0);

    typedef enum logic {
        TRAIN = 1'b0,
        LINK  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (MIN_IDLE == 0) ? LINK : TRAIN;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [DATA_W-1:0]   sr_q,        sr_d;
    logic                word_sync_q, word_sync_d;
    logic                is_data_q,   is_data_d;
    logic [TRAIN_W-1:0]  train_cnt_q, train_cnt_d;
    logic                link_up_q,   link_up_d;
    logic [DATA_W-1:0]   load_word;
    logic                boundary;
    logic                fill_bit;

`ifdef SER_PARITY_EN
    logic par_q, par_d;

    // In parity mode, the shift register fills with the frame's parity bit. After DATA_W
    // shifts, that bit reaches the MSB, so it is sent in the extra frame cycle.
    assign fill_bit = par_q;
    assign par_d    = boundary ? ^load_word : par_q;

    // Capture the parity of the word loaded at each frame boundary.
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`else
    assign fill_bit = 1'b0;
`endif

    assign boundary = (cnt_q == CNT_LAST);

    // Next-state logic. On a boundary, choose the next word and restart the frame.
    // Otherwise, shift the current word out one bit per cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        sr_d        = {sr_q[DATA_W-2:0], fill_bit};
        word_sync_d = 1'b0;
        is_data_d   = is_data_q;
        train_cnt_d = train_cnt_q;
        link_up_d   = link_up_q;
        load_word   = IDLE_SYM;
        ready       = 1'b0;

        if (boundary) begin
            cnt_d       = '0;
            word_sync_d = 1'b1;
            case (state_q)
                TRAIN: begin
                    is_data_d   = 1'b0;
                    train_cnt_d = train_cnt_q + 1'b1;
                    if (train_cnt_q == TRAIN_LAST) begin
                        state_d   = LINK;
                        link_up_d = 1'b1;
                    end
                end
                LINK: begin
                    if (valid_in) begin
                        load_word = data_in;
                        is_data_d = 1'b1;
                        ready     = reset;
                    end else begin
                        is_data_d = 1'b0;
                    end
                end
                default: begin
                    state_d = RESET_STATE;
                end
            endcase
            sr_d = load_word;
        end
    end

    // State registers. Reset leaves the design one cycle before a frame boundary.
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            state_q     <= RESET_STATE;
            cnt_q       <= CNT_LAST;
            sr_q        <= '0;
            word_sync_q <= 1'b0;
            is_data_q   <= 1'b0;
            train_cnt_q <= '0;
            link_up_q   <= (MIN_IDLE == 0);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            word_sync_q <= word_sync_d;
            is_data_q   <= is_data_d;
            train_cnt_q <= train_cnt_d;
            link_up_q   <= link_up_d;
        end
    end

    assign data_out  = sr_q[DATA_W-1];
    assign word_sync = word_sync_q;
    assign is_data   = is_data_q;
    assign link_up   = link_up_q;

endmodule

// File: tb/tb_piso_serializer_param.sv
// tb_piso_serializer_param: drives piso_serializer_param with directed and random
// traffic. It checks every cycle against a frame-level reference model: a queue of
// expected serial bits.
`timescale 1ns/1ps
module tb_piso_serializer_param;

    localparam int                DATA_W   = 8;
    localparam logic [DATA_W-1:0] IDLE_SYM = 8'hBC;
    localparam int                MIN_IDLE = 2;
`ifdef SER_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif
    localparam int FRAME_LEN = DATA_W + (PARITY ? 1 : 0);

    logic              clk_8f = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              data_out;
    logic              ready;
    logic              word_sync;
    logic              is_data;
    logic              link_up;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state.
    bit                exp_q[$];
    int                train_frames = 0;
    bit                exp_dout;
    bit                exp_sync;
    bit                exp_is_data;
    bit                exp_link;
    logic [DATA_W-1:0] tx_q[$];

    piso_serializer_param #(
        .DATA_W   (DATA_W),
        .IDLE_SYM (IDLE_SYM),
        .MIN_IDLE (MIN_IDLE)
    ) dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .ready     (ready),
        .word_sync (word_sync),
        .is_data   (is_data),
        .link_up   (link_up)
    );

    // Free-running bit clock.
    always #5 clk_8f = ~clk_8f;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic boundExpired(input string tag);
        n_compared++;
        n_mismatched++;
        $error("[TB] FAIL %s: wait bound expired", tag);
    endtask

    // One clock cycle: drive the inputs, check ready before the edge, advance the model,
    // and check the registered outputs after the edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [DATA_W-1:0] d,
                                 output bit consumed);
        bit                exp_ready;
        logic [DATA_W-1:0] w;
        bit                carries_data;
        reset    = r;
        valid_in = v;
        data_in  = d;
        #1;
        exp_ready = r && (exp_q.size() == 0) && (train_frames >= MIN_IDLE) && v;
        checkOutput("ready", ready, exp_ready);
        consumed = exp_ready;
        @(posedge clk_8f);
        if (!r) begin
            exp_q.delete();
            train_frames = 0;
            exp_dout     = 1'b0;
            exp_sync     = 1'b0;
            exp_is_data  = 1'b0;
        end else begin
            if (exp_q.size() == 0) begin
                if (train_frames < MIN_IDLE) begin
                    w            = IDLE_SYM;
                    carries_data = 1'b0;
                    train_frames++;
                end else if (v) begin
                    w            = d;
                    carries_data = 1'b1;
                end else begin
                    w            = IDLE_SYM;
                    carries_data = 1'b0;
                end
                for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(w[i]);
                if (PARITY) exp_q.push_back(^w);
                exp_sync    = 1'b1;
                exp_is_data = carries_data;
            end else begin
                exp_sync = 1'b0;
            end
            exp_dout = exp_q.pop_front();
        end
        exp_link = (train_frames >= MIN_IDLE);
        #1;
        checkOutput("data_out",  data_out,  exp_dout);
        checkOutput("word_sync", word_sync, exp_sync);
        checkOutput("is_data",   is_data,   exp_is_data);
        checkOutput("link_up",   link_up,   exp_link);
    endtask

    // Offer the head of tx_q when one is pending. Otherwise, optionally toggle valid_in
    // away from frame boundaries only.
    task automatic driveCycle(input logic r, input bit mid_valid);
        bit                v;
        bit                consumed;
        logic [DATA_W-1:0] d;
        if (tx_q.size() > 0) begin
            v = 1'b1;
            d = tx_q[0];
        end else begin
            v = mid_valid && (exp_q.size() != 0);
            d = DATA_W'($urandom);
        end
        applyStimulus(r, v, d, consumed);
        if (consumed && tx_q.size() > 0) void'(tx_q.pop_front());
    endtask

    initial begin
        bit pos_found;

        // Step 1: hold reset low for three cycles, then release it with a word already waiting.
        for (int i = 0; i < 3; i++) driveCycle(1'b0, 1'b0);
        tx_q.push_back(8'hA5);

        // Step 2: training frames come first, then the waiting 0xA5 frame.
        for (int i = 0; i < FRAME_LEN * (MIN_IDLE + 3) && tx_q.size() > 0; i++)
            driveCycle(1'b1, 1'b0);
        if (tx_q.size() > 0) boundExpired("train_then_data");
        for (int i = 0; i < FRAME_LEN; i++) driveCycle(1'b1, 1'b0);

        // Step 3: valid_in pulses only mid-frame, so every frame stays idle.
        for (int i = 0; i < 2 * FRAME_LEN; i++) driveCycle(1'b1, (i % 3) == 1);

        // Step 4: send 0x01 and 0xFF back to back.
        tx_q.push_back(8'h01);
        tx_q.push_back(8'hFF);
        for (int i = 0; i < FRAME_LEN * 4 && tx_q.size() > 0; i++) driveCycle(1'b1, 1'b0);
        if (tx_q.size() > 0) boundExpired("back_to_back");
        for (int i = 0; i < FRAME_LEN; i++) driveCycle(1'b1, 1'b0);

        // Random traffic with idle gaps and mid-frame valid noise.
        for (int i = 0; i < 30 * FRAME_LEN; i++) begin
            if (tx_q.size() == 0 && $urandom_range(0, 5) == 0)
                tx_q.push_back(DATA_W'($urandom));
            driveCycle(1'b1, $urandom_range(0, 1) == 1);
        end
        tx_q.delete();

        // Step 5: assert reset while bit 4 of a 0xA5 frame is on data_out.
        tx_q.push_back(8'hA5);
        pos_found = 1'b0;
        for (int i = 0; i < FRAME_LEN * 4 && !pos_found; i++) begin
            driveCycle(1'b1, 1'b0);
            pos_found = exp_is_data && (exp_q.size() == FRAME_LEN - 4);
        end
        if (!pos_found) boundExpired("reach_bit4");
        tx_q.delete();
        tx_q.push_back(DATA_W'($urandom));
        driveCycle(1'b0, 1'b0);
        for (int i = 0; i < FRAME_LEN * (MIN_IDLE + 2); i++) driveCycle(1'b1, 1'b0);
        tx_q.delete();

        // Random traffic with occasional resets.
        for (int i = 0; i < 40 * FRAME_LEN; i++) begin
            if (tx_q.size() == 0 && $urandom_range(0, 3) == 0)
                tx_q.push_back(DATA_W'($urandom));
            driveCycle(($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
